mul_16_seq: RTL and testbench
=============================

# mul_16_seq

Sequential 16-bit shift-and-add multiplier that sequences a single shared `add_16` adder over 16 iterations to produce the low 16 bits of a product. It is the ALU-side controller for multiply: it accepts operands with a start/ready handshake, drives the adder with partial sums each cycle, and presents a held result with a one-cycle done pulse. The result is correct for both unsigned and two's-complement operands, because the low 16 bits are identical in both cases.

## Interface
- Parameters: none. Width is fixed at 16 to match `add_16`.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; accepted only on an edge where `ready`=1
- a  input  16  multiplicand, sampled on the accept edge
- b  input  16  multiplier, sampled on the accept edge
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  one-cycle pulse: high for exactly the cycle in DONE state
- out  output  16  low 16 bits of a*b; held until the next completion

## Operation
- Internal registers:
  - `acc[15:0]`, partial sum
  - `mcand[15:0]`, shifted multiplicand
  - `mplier[15:0]`, shifted multiplier
  - `cnt[3:0]`, iteration count
  - `res[15:0]`, drives `out`
  - `state`
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with `start`=1: load `mcand`=a, `mplier`=b, `acc`=0, `cnt`=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - If `mplier[0]`=1, `acc` <= add_16(acc, mcand); else `acc` holds.
  - `mcand` <= mcand<<1 (zero fill); `mplier` <= mplier>>1 (zero fill); `cnt` <= cnt+1.
  - On the edge where `cnt`=15: `res` <= final sum (including the bit-15 add); go to DONE.
- DONE: `done`=1; the next edge returns to IDLE unconditionally.
- Arithmetic is modulo 2^16. The adder carry-out is discarded; `add_16` has no carry port.
- There is no early exit. Every operation takes exactly 16 RUN cycles, even when `b`=0.
- `out` = `res`. It changes only on the RUN→DONE edge and never mid-operation.

## Timing
- Reset values: state=IDLE, `ready`=1, `busy`=0, `done`=0, `out`=0x0000. `acc`, `mcand`, `mplier` and `cnt` are all 0.
- Reset is asynchronous. When asserted mid-RUN it aborts the operation immediately: `out` goes to 0 and no `done` pulse follows.
- Latency, with accept edge E0:
  - RUN iterates on edges E1..E16.
  - `done`=1 and the new `out` are valid in the cycle after E16.
  - IDLE and `ready`=1 return after E17.
- Throughput: one operation per 18 cycles. A new start can be accepted on E18 at the earliest.
- `start` during RUN or DONE is ignored, not queued. Operands on `a`/`b` are ignored outside the accept edge.
- `start` held high continuously means back-to-back operations, each re-sampling `a`/`b` on its own accept edge.
- `ready`, `busy` and `done` are decoded from registered state only (no combinational path from `start`). Exactly one of them is high in any cycle.

## Structure
- Shared include `mul_16_defs.vh` holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - `MUL_ITERS`=16
- One sub-module: an `add_16` instance with inputs `acc` and `mcand`, whose output feeds the `acc` next-state mux.
- No second adder. The counter increment uses plain `+1` on a 4-bit register.
- The FSM and datapath live in one file, `mul_16_seq.v`. The testbench is `testbench/mul_16_seq_testbench.v` and uses the shared `assert` macro.

## Test plan
- Reset, then a=0x0003, b=0x0005, start for 1 cycle:
  - `busy` is high for 16 cycles.
  - `done` pulses once.
  - `out`=0x000F and still holds 0x000F 5 cycles later.
- a=0xFFFF, b=0xFFFF -> `out`=0x0001 (wrap-around).
- a=0xFFFD (−3), b=0x0007 -> `out`=0xFFEB (−21).
- a=0x0100, b=0x0100 -> `out`=0x0000.
- a=0x1234, b=0x0010 -> `out`=0x2340.
- Back-to-back and ignored start:
  - Start a=2, b=3; pulse start with a=9, b=9 mid-RUN.
  - Required: a single `done`, `out`=0x0006, then `ready`.
  - A further start with a=9, b=9 -> `out`=0x0051.
- Reset mid-operation:
  - Start a=7, b=7 after a prior result of 0x000F; assert `reset` at RUN cycle 8.
  - Required: `out`=0x0000, `ready`=1 immediately, and no `done` pulse within the following 20 cycles.

Source files
------------

// File: rtl/mul_16_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_16_seq_pkg
//  Description : Shared state encoding and iteration constants for the
//                sequential 16-bit shift-and-add multiplier.
//  Revision    : 1.0
// ============================================================================
package mul_16_seq_pkg;

   // Controller states; encoding fixed so IDLE is the all-zero reset value
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // One iteration per multiplier bit, no early exit
   localparam int         MUL_ITERS = 16;
   localparam logic [3:0] LAST_ITER = 4'(MUL_ITERS - 1);

endpackage
`default_nettype wire

// File: rtl/mul_16_seq_add_16.sv
`default_nettype none
// ============================================================================
//  Module      : mul_16_seq_add_16
//  Description : 16-bit adder shared by the multiplier datapath. The carry
//                out is dropped, so the result is modulo 2^16.
//  Revision    : 1.0
// ============================================================================
module mul_16_seq_add_16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] sum_o
);

   // Plain modulo-2^16 sum
   assign sum_o = a_i + b_i;

endmodule
`default_nettype wire

// File: rtl/mul_16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_16_seq
//  Description : Sequential 16x16 shift-and-add multiplier returning the low
//                16 bits of the product. One shared adder, 16 RUN cycles per
//                operation, start/ready handshake and a one-cycle done pulse.
//  Revision    : 1.0
// ============================================================================
module mul_16_seq
   import mul_16_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] out
);

   state_t      state_q;
   logic        ready_q;
   logic        busy_q;
   logic        done_q;
   logic [15:0] acc_q;
   logic [15:0] mcand_q;
   logic [15:0] mplier_q;
   logic [3:0]  cnt_q;
   logic [15:0] res_q;

   logic [15:0] sum_w;
   logic [15:0] acc_d;
   logic [15:0] mcand_d;
   logic [15:0] mplier_d;
   logic [3:0]  cnt_d;

   // The only adder in the design: partial sum plus shifted multiplicand
   mul_16_seq_add_16 u_add_16 (
      .a_i   (acc_q),
      .b_i   (mcand_q),
      .sum_o (sum_w)
   );

   // Next values for one RUN iteration; accumulate only when the current
   // multiplier bit is set
   always_comb begin
      acc_d    = mplier_q[0] ? sum_w : acc_q;
      mcand_d  = {mcand_q[14:0], 1'b0};
      mplier_d = {1'b0, mplier_q[15:1]};
      cnt_d    = cnt_q + 4'd1;
   end

   // Controller and datapath registers; status outputs are registered
   // alongside the state so exactly one of ready/busy/done is high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q  <= a;
                  mplier_q <= b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= RUN;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_d;
               if (cnt_q == LAST_ITER) begin
                  // Capture the sum including the final bit's add
                  res_q   <= acc_d;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign out   = res_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_16_seq
//  Description : Directed self-checking bench for mul_16_seq.
//  Revision    : 1.0
// ============================================================================
module tb_mul_16_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] out;

   int n_tests = 0;
   int n_fail  = 0;

   mul_16_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Launch one operation and follow it until ready returns. Optionally
   // pulses start with a=9,b=9 in the middle of RUN to show it is ignored.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input bit inject,
                        output int busy_cnt, output int done_cnt, output int bad_hot,
                        output int out_chg, output bit got_ready);
      logic [15:0] prev_out;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb;
      @(negedge clk);
      start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
      busy_cnt = 0; done_cnt = 0; bad_hot = 0; out_chg = 0; got_ready = 1'b0;
      prev_out = out;
      for (int i = 0; i < 40; i++) begin
         if (int'(ready) + int'(busy) + int'(done) != 1) bad_hot++;
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (busy && out !== prev_out) out_chg++;
         if (ready) begin
            got_ready = 1'b1;
            break;
         end
         if (inject && i == 5) begin start = 1'b1; a = 16'd9; b = 16'd9; end
         if (inject && i == 6) begin start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
      string       tag;
   } vec_t;

   initial begin
      int bc, dc, bh, oc;
      bit rdy;
      vec_t vecs[4];
      vecs[0] = '{16'hFFFF, 16'hFFFF, 16'h0001, "wrap"};
      vecs[1] = '{16'hFFFD, 16'h0007, 16'hFFEB, "neg3x7"};
      vecs[2] = '{16'h0100, 16'h0100, 16'h0000, "overflow_zero"};
      vecs[3] = '{16'h1234, 16'h0010, 16'h2340, "shift4"};

      reset = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_busy",  busy,  0);
      check("rst_done",  done,  0);
      check("rst_out",   out,   0);
      reset = 1'b0;
      @(negedge clk);

      // 3 * 5 with full latency and hold checks
      do_op(16'h0003, 16'h0005, 1'b0, bc, dc, bh, oc, rdy);
      check("op1_ready_ret", rdy, 1);
      check("op1_busy_cycles", bc, 16);
      check("op1_done_pulses", dc, 1);
      check("op1_onehot", bh, 0);
      check("op1_out", out, 16'h000F);
      repeat (5) @(negedge clk);
      check("op1_hold", out, 16'h000F);

      // Directed vectors
      foreach (vecs[k]) begin
         do_op(vecs[k].a, vecs[k].b, 1'b0, bc, dc, bh, oc, rdy);
         check({vecs[k].tag, "_ready_ret"}, rdy, 1);
         check({vecs[k].tag, "_busy_cycles"}, bc, 16);
         check({vecs[k].tag, "_out_stable"}, oc, 0);
         check(vecs[k].tag, out, vecs[k].exp);
      end

      // Start during RUN must be ignored
      do_op(16'd2, 16'd3, 1'b1, bc, dc, bh, oc, rdy);
      check("ign_ready_ret", rdy, 1);
      check("ign_done_pulses", dc, 1);
      check("ign_out", out, 16'h0006);
      @(negedge clk);
      check("ign_no_restart", ready, 1);
      do_op(16'd9, 16'd9, 1'b0, bc, dc, bh, oc, rdy);
      check("nine_sq", out, 16'h0051);

      // Reset mid-operation after a prior result of 0x000F
      do_op(16'h0003, 16'h0005, 1'b0, bc, dc, bh, oc, rdy);
      check("pre_rst_out", out, 16'h000F);
      @(negedge clk);
      start = 1'b1; a = 16'd7; b = 16'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("mid_busy", busy, 1);
      reset = 1'b1;
      #1;
      check("abort_out", out, 0);
      check("abort_ready", ready, 1);
      check("abort_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      dc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) dc++;
      end
      check("abort_no_done", dc, 0);
      check("abort_idle", ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
